// File: rtl/qam64_symbol_demapper.sv
// 64-QAM hard-decision demapper: slices I/Q to the nearest level, Gray-decodes and serialises 6 bits/symbol.
// Optional off-grid counter is built when DEMAP_ERRCNT_EN is defined.
module qam64_symbol_demapper #(
  parameter int CNT_W   = 16,
  parameter int I_FIRST = 1
) (
  input  logic             data_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             symbol_valid,
  input  logic [3:0]       i_data,
  input  logic [3:0]       q_data,
  output logic             symbol_ready,
  input  logic             bit_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             symbol_start,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [5:0]        sym_p1, sym_nxt;
  logic [5:0]        sym_p0;
  logic signed [3:0] i_s, q_s;
  logic              transfer;
  logic              last_bit;

  // Nearest level via (x+8)>>1, then binary-to-Gray; even inputs land on the level above.
  function automatic logic [2:0] slice_gray(input logic signed [3:0] x);
    logic signed [4:0] biased;
    logic [2:0]        idx;
    biased = 5'(x) + 5'sd8;
    idx    = 3'(biased >>> 1);
    return idx ^ (idx >> 1);
  endfunction

  assign i_s    = i_data;
  assign q_s    = q_data;
  assign sym_p0 = (I_FIRST != 0) ? {slice_gray(i_s), slice_gray(q_s)}
                                 : {slice_gray(q_s), slice_gray(i_s)};

  assign last_bit     = (state == SHIFT) && (bit_cnt == 3'd5);
  assign symbol_ready = enable & ~rst & ((state == IDLE) | (last_bit & bit_ready));
  assign transfer     = symbol_valid & symbol_ready;

  assign bit_valid    = (state == SHIFT) & ~rst;
  assign data_out     = bit_valid & sym_p1[3'd5 - bit_cnt];
  assign symbol_start = bit_valid & (bit_cnt == 3'd0);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sym_nxt     = sym_p1;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 3'd0;
          sym_nxt     = sym_p0;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          if (!last_bit) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else if (transfer) begin
            bit_cnt_nxt = 3'd0;
            sym_nxt     = sym_p0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: held symbol word and serialiser position
  always_ff @(posedge data_clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      sym_p1  <= 6'd0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sym_p1  <= sym_nxt;
    end
  end

`ifdef DEMAP_ERRCNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  logic [CNT_W-1:0] err_cnt_p1;

  always_ff @(posedge data_clk) begin
    if (rst) begin
      err_cnt_p1 <= '0;
    end else if (transfer && (!i_data[0] || !q_data[0])) begin
      err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  assign err_count = err_cnt_p1;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/qam64_symbol_demapper.md
Name: qam64_symbol_demapper

Overview:
- Receive-side counterpart of the baseband data mapper.
- Accepts one 64-QAM symbol at a time as 4-bit signed I and Q samples through a valid/ready handshake.
- Each axis is sliced to the nearest constellation level, Gray-decoded to 3 bits and serialised to a 1-bit stream with downstream backpressure.
- Sits between the demodulator's I/Q sample FIFO and the receive bit sink.

Parameters:
- CNT_W, 16, width of the off-grid symbol counter (used only when DEMAP_ERRCNT_EN is defined).
- I_FIRST, 1, when 1 the three I bits are sent before the three Q bits; when 0, Q bits go first.

Ports:
- data_clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new symbol is accepted; a symbol already being shifted out completes.
- symbol_valid  input  1  an I/Q sample pair is present.
- i_data  input  4  I sample, two's complement, -8..7.
- q_data  input  4  Q sample, two's complement, -8..7.
- symbol_ready  output  1  block accepts a pair this cycle.
- bit_ready  input  1  downstream can take data_out this cycle.
- data_out  output  1  serial recovered bit.
- bit_valid  output  1  data_out is valid.
- symbol_start  output  1  high with the first bit of each symbol.
- err_count  output  CNT_W  off-grid symbol count (feature only).

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - State returns to IDLE; bit_cnt=0; shift register cleared.
  - data_out=0, bit_valid=0, symbol_start=0, symbol_ready=0 during the reset cycle; err_count=0.
  - Reset mid-symbol discards the remaining bits. No partial symbol is ever resumed.
- Slicer (combinational, per axis):
  - idx = {~x[3], x[2:1]}, i.e. idx = (x+8)>>1. Level = 2*idx-7.
  - Even inputs round toward +infinity: -8→-7, -6→-5, 0→+1, 6→+7.
- Gray decode: g = idx ^ (idx>>1), giving levels -7..+7 → 000,001,011,010,110,111,101,100.
- Symbol word: sym[5:0] = {gI,gQ} if I_FIRST=1, else {gQ,gI}. Bits are sent MSB first.
- Handshake in: transfer occurs when symbol_valid & symbol_ready at a clock edge.
  - symbol_ready = enable & ~rst & (state==IDLE | (state==SHIFT & bit_cnt==5 & bit_ready)).
  - symbol_ready is combinational from state, enable and bit_ready.
- Handshake out: a bit is consumed when bit_valid & bit_ready. While bit_ready=0, data_out, bit_valid, symbol_start and bit_cnt hold.
- FSM:
  - IDLE: bit_valid=0. On transfer, load sym, go to SHIFT with bit_cnt=0.
  - SHIFT: bit_valid=1; data_out=sym[5-bit_cnt]; symbol_start=(bit_cnt==0).
    - On consume with bit_cnt<5: bit_cnt+1.
    - On consume with bit_cnt==5 and a simultaneous transfer: load the new sym, stay in SHIFT, bit_cnt=0.
    - On consume with bit_cnt==5 and no transfer: go to IDLE.
- Latency: transfer at edge N gives the first bit on the outputs after edge N. Back-to-back symbols with bit_ready=1 produce a gap-free stream of 6 bits per 6 cycles.
- enable deasserted mid-symbol: the current 6 bits still complete; no new transfer occurs.
- symbol_valid while not ready: the sample pair is not sampled; the upstream side holds it.

Optional Feature:
- DEMAP_ERRCNT_EN defined:
  - On each transfer where i_data[0]==0 or q_data[0]==0 (an even, off-grid sample on either axis), err_count increments by 1.
  - err_count saturates at all-ones and clears only on rst.
- DEMAP_ERRCNT_EN undefined: no counter logic is built; err_count is tied to 0.

Test Plan:
- Reset then i=7, q=-7, bit_ready=1 → bits 1,0,0,0,0,0; symbol_start on the first bit only; symbol_ready=1 on the 6th bit.
- Back-to-back (7,-7) then (-1,1) with symbol_valid held → 12 contiguous bits 100000 010110; bit_valid never drops.
- Off-grid (-6,0) → bits 001110. With DEMAP_ERRCNT_EN, err_count 0→1; a following (7,7) leaves err_count at 1.
- bit_ready=0 for 3 cycles at bit 2 of (-1,1) → data_out=0, bit_valid=1, symbol_ready=0 held; the stream resumes with bit_cnt unchanged.
- rst pulsed at bit 3 of (7,-7) → the following cycle has bit_valid=0 and state IDLE; a new (1,1) gives 110110.
- I_FIRST=0, enable=0 at bit 4 of (7,-7) → the symbol completes as 000100; the next symbol is not accepted until enable=1.
